// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, ROM address drive, and a small
// circular buffer of {instr, pc+4} entries handed to decode over valid/ready.
module fetch_stage #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc_plus4,
    output logic [CNT_W-1:0] fetch_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   pc_next4;
    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          pop;
    logic          push;
    logic          unused_low_bits;

    // Handshake: a transfer happens on any rising edge where if_valid and
    // if_ready are both 1; while if_valid=1 and if_ready=0 the head is held
    // unchanged, and if_ready is ignored when if_valid=0 or redirect=1.
    assign pc_next4  = pc + 32'd4;
    assign imem_addr = pc;
    assign if_valid  = (count != '0);
    assign pop       = if_valid & if_ready;
    assign push      = ~redirect & ((count < FULL) | pop);

    assign if_instr    = if_valid ? mem[rd_ptr][63:32] : 32'h0;
    assign if_pc_plus4 = if_valid ? mem[rd_ptr][31:0]  : 32'h0;

    assign unused_low_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_count <= '0;
        end else if (redirect) begin
            // Flush wins over any same-cycle pop or push.
            pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                pc     <= pc_next4;
                if (fetch_count != '1) begin
                    fetch_count <= fetch_count + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {imem_data, pc_next4};
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_stage;
    localparam int          DEPTH    = 2;
    localparam int          CNT_W    = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_data;
    logic             redirect = 1'b0;
    logic [31:0]      redirect_pc = 32'h0;
    logic             if_valid;
    logic             if_ready = 1'b0;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc_plus4;
    logic [CNT_W-1:0] fetch_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_ready(if_ready), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
        .fetch_count(fetch_count)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a[31:2])
            30'd0:   return 32'h0000_0000;
            30'd1:   return 32'h8001_060A;
            default: return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
        endcase
    endfunction

    assign imem_data = rom(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a FIFO of fetched {word, addr+4} pairs.
    logic [63:0] q[$];
    logic [31:0] m_pc;
    int          m_fcnt;

    task automatic model_reset();
        q.delete();
        m_pc   = {RESET_PC[31:2], 2'b00};
        m_fcnt = 0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic mstep(input logic r, input logic [31:0] rpc, input logic rdy, input bit do_chk);
        int  n;
        bit  p;
        redirect    = r;
        redirect_pc = rpc;
        if_ready    = rdy;
        #1;
        n = q.size();
        if (do_chk) begin
            chk("m_valid", {31'h0, if_valid}, (n > 0) ? 32'h1 : 32'h0);
            chk("m_instr", if_instr, (n > 0) ? q[0][63:32] : 32'h0);
            chk("m_pc4", if_pc_plus4, (n > 0) ? q[0][31:0] : 32'h0);
            chk("m_addr", imem_addr, m_pc);
            chk("m_fcnt", 32'(fetch_count), 32'(m_fcnt));
        end
        p = (n > 0) && rdy;
        if (r) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (p) void'(q.pop_front());
            if (n < DEPTH || p) begin
                q.push_back({rom(m_pc), m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
                if (m_fcnt < (1 << CNT_W) - 1) m_fcnt++;
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        do_reset;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic [31:0] exp_addr;
        logic [31:0] exp_fcnt;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic rs, input logic rd, input logic v,
                                input logic [31:0] ins, input logic [31:0] p4,
                                input logic [31:0] ad, input logic [31:0] fc);
        vec_t t;
        t.do_reset = rs; t.ready = rd; t.exp_valid = v; t.exp_instr = ins;
        t.exp_pc4 = p4; t.exp_addr = ad; t.exp_fcnt = fc;
        return t;
    endfunction

    initial begin
        // Streaming from reset with decode always ready.
        vecs[0] = mk(1, 1, 0, 32'h0, 32'h0, 32'h0, 0);
        vecs[1] = mk(0, 1, 1, 32'h0, 32'h4, 32'h4, 1);
        vecs[2] = mk(0, 1, 1, 32'h8001_060A, 32'h8, 32'h8, 2);
        // Back-pressure from reset: fill, hold head 10 cycles, then drain.
        vecs[3] = mk(1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        vecs[4] = mk(0, 0, 1, 32'h0, 32'h4, 32'h4, 1);
        for (int j = 2; j < 12; j++) vecs[3 + j] = mk(0, 0, 1, 32'h0, 32'h4, 32'h8, 2);
        vecs[15] = mk(0, 1, 1, 32'h0, 32'h4, 32'h8, 2);
        vecs[16] = mk(0, 1, 1, 32'h8001_060A, 32'h8, 32'hC, 3);
        vecs[17] = mk(0, 1, 1, rom(32'h8), 32'hC, 32'h10, 4);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].do_reset) reset_pulse();
            redirect = 1'b0;
            if_ready = vecs[i].ready;
            #1;
            chk($sformatf("vec%0d_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_instr", i), if_instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_pc4", i), if_pc_plus4, vecs[i].exp_pc4);
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_fcnt", i), 32'(fetch_count), vecs[i].exp_fcnt);
            @(negedge clk);
        end

        // Redirect while full to a misaligned target.
        reset_pulse();
        for (int i = 0; i < 3; i++) mstep(0, 32'h0, 0, 1);
        mstep(1, 32'h0000_005E, 0, 1);
        chk("redir_full_valid", {31'h0, if_valid}, 32'h0);
        chk("redir_full_addr", imem_addr, 32'h0000_005C);
        mstep(0, 32'h0, 1, 1);
        chk("redir_full_pc4", if_pc_plus4, 32'h0000_0060);
        chk("redir_full_instr", if_instr, rom(32'h0000_005C));
        for (int i = 0; i < 4; i++) mstep(0, 32'h0, 1, 1);

        // Redirect and ready on the same edge: head not consumed, flushed.
        mstep(1, 32'h0000_0100, 1, 1);
        chk("redir_rdy_valid", {31'h0, if_valid}, 32'h0);
        chk("redir_rdy_addr", imem_addr, 32'h0000_0100);
        mstep(0, 32'h0, 1, 1);
        chk("redir_rdy_pc4", if_pc_plus4, 32'h0000_0104);

        // PC wrap at the top of the address space.
        mstep(1, 32'hFFFF_FFFC, 1, 1);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        mstep(0, 32'h0, 1, 1);
        chk("wrap_pc4", if_pc_plus4, 32'h0000_0000);
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        mstep(0, 32'h0, 1, 1);
        chk("wrap_addr2", imem_addr, 32'h0000_0004);

        // Asynchronous reset between clock edges while streaming.
        for (int i = 0; i < 5; i++) mstep(0, 32'h0, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'h0, if_valid}, 32'h0);
        chk("arst_addr", imem_addr, RESET_PC);
        chk("arst_fcnt", 32'(fetch_count), 32'h0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) mstep(0, 32'h0, 1, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            mstep(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 3) != 0), 1);
        end

        // Saturation of the fetched-instruction counter.
        reset_pulse();
        for (int i = 0; i < (1 << CNT_W) + 4; i++) mstep(0, 32'h0, 1, 0);
        chk("fcnt_sat", 32'(fetch_count), 32'h0000_FFFF);
        for (int i = 0; i < 4; i++) mstep(0, 32'h0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end. Holds the program counter, drives the byte address into the combinational instruction ROM, and captures the returned word with its PC+4 into a small instruction buffer.
- The buffer decouples fetch from the decode/control stage through a valid/ready handshake.
- Accepts taken-branch/jump redirects from execute, which flush the buffer.
- Upstream of decode; the instruction ROM is its memory-side partner.

Parameters:
- DEPTH, 2, instruction-buffer entries (power of two, >=2)
- RESET_PC, 32'h0000_0000, PC loaded on reset
- CNT_W, 16, width of the fetched-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_addr  out  32  byte address to instruction ROM, equal to PC
- imem_data  in  32  instruction word returned combinationally for imem_addr in the same cycle
- redirect  in  1  taken branch/jump from execute
- redirect_pc  in  32  redirect target (byte address)
- if_valid  out  1  buffer head holds a valid instruction
- if_ready  in  1  decode accepts the head this cycle
- if_instr  out  32  head instruction word
- if_pc_plus4  out  32  head instruction address + 4
- fetch_count  out  CNT_W  instructions pushed into the buffer since reset, saturating

Behaviour:
- State:
  - pc[31:0], with bits [1:0] always 0.
  - DEPTH x 64-bit entry array.
  - Read pointer, write pointer, occupancy count[log2(DEPTH):0].
  - fetch_count.
- Reset (async, while rst=1):
  - pc=RESET_PC with [1:0] forced to 0; pointers=0; count=0; fetch_count=0.
  - if_valid=0. if_instr=0 and if_pc_plus4=0 whenever if_valid=0.
- imem_addr = pc at all times (combinational).
- pop = if_valid & if_ready.
- push = ~redirect & (count<DEPTH | pop). Push while full is legal only when a pop happens in the same cycle.
- Rising edge, rst=0, priority high to low:
  1. redirect=1:
     - All entries discarded; count=0; pointers=0.
     - pc = {redirect_pc[31:2],2'b00}.
     - No push and no pop that cycle; an if_ready in the same cycle is ignored.
     - if_valid=0 for the cycle after the edge.
  2. Otherwise:
     - On pop, the head is retired.
     - On push, the entry {imem_data, pc+4} is written at the write pointer and pc = pc+4.
     - Without push, pc holds.
     - count += push - pop.
- Latency:
  - Instruction at pc appears on if_instr one cycle after the edge that pushed it (one cycle after reset release or redirect).
  - Sustained throughput is 1 instruction/cycle while if_ready=1.
- Outputs if_valid, if_instr, if_pc_plus4 reflect the head entry: count>0, registered storage, no combinational path from imem_data.
- Head is held stable while if_valid=1 and if_ready=0.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); no error.
- Misaligned redirect_pc: low two bits dropped silently.
- Empty: if_valid=0; if_ready is ignored.
- Full with if_ready=0: pc and imem_addr frozen; no push.
- fetch_count increments on every push and sticks at 2^CNT_W-1.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk.
- No other sequential side effects; instruction contents are not decoded by this block.

Test Plan:
- Reset release with ROM word0=0x0000_0000 and word1=0x8001_060A, if_ready=1:
  - imem_addr is 0x0, then 0x4, then 0x8 on consecutive cycles.
  - if_instr/if_pc_plus4 is 0x0/0x4, then 0x8001060A/0x8.
  - if_valid rises one cycle after the release.
- Back-pressure with if_ready=0 from reset (DEPTH=2):
  - After two edges, count=2 and imem_addr is stuck at 0x8.
  - Head stays 0x0/0x4 for 10 cycles.
  - fetch_count=2.
  - Raising if_ready drains in order 0x4, 0x8, 0xC with no gaps or duplicates.
- Redirect while full, redirect_pc=0x0000005E:
  - Next cycle if_valid=0 and imem_addr=0x5C.
  - The following head has if_pc_plus4=0x60 and equals the ROM word 23.
  - Stale entries are never presented.
- Redirect and if_ready=1 asserted on the same edge: the head is not counted as consumed, the buffer is flushed, and the new stream starts at the target.
- Wrap: redirect_pc=0xFFFF_FFFC gives head pc_plus4=0x0000_0000, then imem_addr continues 0x0, 0x4.
- Async reset pulse between clock edges during streaming: if_valid=0 and imem_addr=RESET_PC immediately, before the next clk edge; fetch_count=0.
